// File: rtl/peaks_reader.sv
// peaks_reader
//   Captures each new peak set published by the peaks stage into a DEPTH-frame
//   FIFO and exposes the head frame and status to the HPS over a 32-bit slave.
//
// Ports
//   clk, reset       system clock, asynchronous active-high reset
//   counter_in       frame counter from the peaks stage (changes once per frame)
//   freqs_in         PEAKS packed frequency indices, peak i at [i*FREQ_W +: FREQ_W]
//   amplitudes_in    PEAKS packed signed amplitudes, peak i at [i*AMPL_W +: AMPL_W]
//   chipselect       slave select qualifying read/write
//   read, write      slave strobes
//   address          register index (0 STATUS, 1 HEAD_TIME, 2.. HEAD_PEAK i)
//   writedata        write data (addr 0: bit0 pop, bit1 clear OVF/GAP/drop)
//   readdata         registered read data, updated on each qualified read
module peaks_reader #(
   parameter int PEAKS  = 6,
   parameter int FREQ_W = 8,
   parameter int AMPL_W = 8,
   parameter int TIME_W = 16,
   parameter int DEPTH  = 16
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic        [TIME_W-1:0]         counter_in,
   input  logic        [PEAKS*FREQ_W-1:0]   freqs_in,
   input  logic signed [PEAKS*AMPL_W-1:0]   amplitudes_in,
   input  logic                             chipselect,
   input  logic                             read,
   input  logic                             write,
   input  logic        [3:0]                address,
   input  logic        [31:0]               writedata,
   output logic        [31:0]               readdata
);

   localparam int FTOT  = PEAKS * FREQ_W;
   localparam int ATOT  = PEAKS * AMPL_W;
   localparam int REC_W = TIME_W + FTOT + ATOT;
   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   // Record layout: {counter, freqs, amplitudes}
   logic [REC_W-1:0]  s1_q, s1_d, s2_q, s2_d;
   logic [TIME_W-1:0] last_counter_q, last_counter_d;
   logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic              ovf_q, ovf_d, gap_q, gap_d;
   logic [7:0]        drop_q, drop_d;
   logic [31:0]       readdata_q, readdata_d;
   logic [REC_W-1:0]  fifo_q [DEPTH];

   logic [TIME_W-1:0] s2_cnt, expect_cnt, head_cnt;
   logic [REC_W-1:0]  head;
   logic [PTR_W-1:0]  count;
   logic              empty, full, capture, pop_req, clr_req;
   logic              do_pop, do_push, overflow;
   logic [31:0]       status, rd_word;
   logic [FREQ_W-1:0] pk_f;
   logic signed [AMPL_W-1:0] pk_a;
   logic              unused_wd;

   assign unused_wd = ^writedata[31:2];
   assign readdata  = readdata_q;

   always_comb begin
      s1_d       = {counter_in, freqs_in, amplitudes_in};
      s2_d       = s1_q;
      s2_cnt     = s2_q[REC_W-1 -: TIME_W];
      expect_cnt = last_counter_q + TIME_W'(1);

      count = wptr_q - rptr_q;
      empty = (count == '0);
      full  = (count == PTR_W'(DEPTH));

      // Two identical consecutive samples guard against catching a frame mid-update
      capture = (s1_q == s2_q) && (s2_cnt != last_counter_q);

      pop_req = chipselect && write && (address == 4'd0) && writedata[0];
      clr_req = chipselect && write && (address == 4'd0) && writedata[1];

      // A pop on a full FIFO frees the slot the simultaneous push needs
      do_pop   = pop_req && !empty;
      do_push  = capture && (!full || do_pop);
      overflow = capture && full && !do_pop;

      last_counter_d = capture ? s2_cnt : last_counter_q;
      wptr_d = do_push ? wptr_q + PTR_W'(1) : wptr_q;
      rptr_d = do_pop  ? rptr_q + PTR_W'(1) : rptr_q;

      // Clear first so an event in the same cycle is not lost
      ovf_d  = clr_req ? 1'b0 : ovf_q;
      gap_d  = clr_req ? 1'b0 : gap_q;
      drop_d = clr_req ? 8'd0 : drop_q;
      if (overflow) begin
         ovf_d = 1'b1;
         if (drop_d != 8'hFF) drop_d = drop_d + 8'd1;
      end
      if (capture && (s2_cnt != expect_cnt)) gap_d = 1'b1;

      status        = '0;
      status[7:0]   = 8'(count);
      status[8]     = empty;
      status[9]     = full;
      status[10]    = ovf_q;
      status[11]    = gap_q;
      status[23:16] = drop_q;

      head     = fifo_q[rptr_q[IDX_W-1:0]];
      head_cnt = head[REC_W-1 -: TIME_W];

      pk_f    = '0;
      pk_a    = '0;
      rd_word = '0;
      if (address == 4'd0) begin
         rd_word = status;
      end else if (!empty) begin
         if (address == 4'd1) rd_word = 32'(head_cnt);
         for (int i = 0; i < PEAKS; i++) begin
            if (address == 4'(i + 2)) begin
               pk_f    = head[ATOT + i*FREQ_W +: FREQ_W];
               pk_a    = head[i*AMPL_W +: AMPL_W];
               rd_word = {16'(pk_a), 16'(pk_f)};
            end
         end
      end

      readdata_d = (chipselect && read) ? rd_word : readdata_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q           <= '0;
         s2_q           <= '0;
         last_counter_q <= '0;
         wptr_q         <= '0;
         rptr_q         <= '0;
         ovf_q          <= 1'b0;
         gap_q          <= 1'b0;
         drop_q         <= '0;
         readdata_q     <= '0;
      end else begin
         s1_q           <= s1_d;
         s2_q           <= s2_d;
         last_counter_q <= last_counter_d;
         wptr_q         <= wptr_d;
         rptr_q         <= rptr_d;
         ovf_q          <= ovf_d;
         gap_q          <= gap_d;
         drop_q         <= drop_d;
         readdata_q     <= readdata_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      end else if (do_push) begin
         fifo_q[wptr_q[IDX_W-1:0]] <= s2_q;
      end
   end

endmodule

// File: tb/tb_peaks_reader.sv
module tb_peaks_reader;
   localparam int PEAKS = 6;
   localparam int DEPTH = 16;

   typedef struct packed {
      logic [15:0] t;
      logic [47:0] f;
      logic [47:0] a;
   } rec_t;

   logic               clk = 1'b0;
   logic               reset;
   logic        [15:0] counter_in;
   logic        [47:0] freqs_in;
   logic signed [47:0] amplitudes_in;
   logic               chipselect, read, write;
   logic        [3:0]  address;
   logic        [31:0] writedata, readdata;

   rec_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   logic        ovf_m, gap_m;
   int          drop_m;
   logic [15:0] last_m;

   always #5 clk = ~clk;

   peaks_reader #(.PEAKS(6), .FREQ_W(8), .AMPL_W(8), .TIME_W(16), .DEPTH(16)) dut (
      .clk(clk), .reset(reset), .counter_in(counter_in), .freqs_in(freqs_in),
      .amplitudes_in(amplitudes_in), .chipselect(chipselect), .read(read),
      .write(write), .address(address), .writedata(writedata), .readdata(readdata)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic rec_t gen(input logic [15:0] c);
      rec_t r;
      r.t = c;
      for (int i = 0; i < PEAKS; i++) begin
         r.f[i*8 +: 8] = 8'(c * 7 + i * 37);
         r.a[i*8 +: 8] = 8'(c * 29 - i * 45);
      end
      return r;
   endfunction

   function automatic logic [31:0] peak_word(input rec_t r, input int i);
      logic [7:0] a, f;
      a = r.a[i*8 +: 8];
      f = r.f[i*8 +: 8];
      return {{8{a[7]}}, a, 8'h00, f};
   endfunction

   task automatic model_frame(input rec_t r);
      if (r.t != last_m) begin
         if (r.t != 16'(last_m + 16'd1)) gap_m = 1'b1;
         if (sb.size() == DEPTH) begin
            ovf_m = 1'b1;
            if (drop_m < 255) drop_m++;
         end else begin
            sb.push_back(r);
         end
         last_m = r.t;
      end
   endtask

   task automatic drive(input rec_t r, input int hold);
      @(negedge clk);
      counter_in    = r.t;
      freqs_in      = r.f;
      amplitudes_in = r.a;
      model_frame(r);
      repeat (hold) @(negedge clk);
   endtask

   task automatic rd(input logic [3:0] a, output logic [31:0] d);
      @(negedge clk);
      chipselect = 1'b1; read = 1'b1; address = a;
      @(negedge clk);
      chipselect = 1'b0; read = 1'b0;
      d = readdata;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
      @(negedge clk);
      chipselect = 1'b0; write = 1'b0;
      if (a == 4'd0) begin
         if (d[0] && sb.size() > 0) void'(sb.pop_front());
         if (d[1]) begin ovf_m = 1'b0; gap_m = 1'b0; drop_m = 0; end
      end
   endtask

   task automatic check_status(input string tag);
      logic [31:0] d, e;
      rd(4'd0, d);
      e = '0;
      e[7:0]   = 8'(sb.size());
      e[8]     = (sb.size() == 0);
      e[9]     = (sb.size() == DEPTH);
      e[10]    = ovf_m;
      e[11]    = gap_m;
      e[23:16] = 8'(drop_m);
      chk(tag, d, e);
   endtask

   task automatic check_head(input string tag);
      logic [31:0] d;
      rd(4'd1, d);
      if (sb.size() == 0) begin
         chk({tag, "_time_empty"}, d, 32'h0);
      end else begin
         chk({tag, "_time"}, d, {16'h0, sb[0].t});
         rd(4'd2, d);
         chk({tag, "_pk0"}, d, peak_word(sb[0], 0));
         rd(4'(2 + PEAKS - 1), d);
         chk({tag, "_pk5"}, d, peak_word(sb[0], PEAKS - 1));
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      counter_in = '0; freqs_in = '0; amplitudes_in = '0;
      sb.delete();
      ovf_m = 1'b0; gap_m = 1'b0; drop_m = 0; last_m = '0;
      #1 chk("rst_readdata", readdata, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      rec_t r;
      logic [31:0] d;
      reset = 1'b1;
      counter_in = '0; freqs_in = '0; amplitudes_in = '0;
      chipselect = 1'b0; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
      ovf_m = 1'b0; gap_m = 1'b0; drop_m = 0; last_m = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Counter held at 0: nothing captured
      repeat (50) @(negedge clk);
      rd(4'd0, d);
      chk("idle_status", d, 32'h0000_0100);
      check_head("idle");

      // Single known frame
      r.t = 16'd1;
      r.f = {8'd230, 8'd160, 8'd110, 8'd70, 8'd40, 8'd3};
      r.a = {8'sd127, -8'sd128, 8'sd100, 8'sd7, 8'sd12, -8'sd5};
      drive(r, 10);
      rd(4'd0, d);
      chk("one_status", d, 32'h0000_0001);
      rd(4'd1, d);
      chk("one_time", d, 32'h0000_0001);
      rd(4'd2, d);
      chk("one_pk0", d, 32'hFFFB_0003);
      rd(4'd6, d);
      chk("one_pk4", d, 32'hFF80_00A0);
      rd(4'd8, d);
      chk("one_addr8", d, 32'h0);
      rd(4'd15, d);
      chk("one_addr15", d, 32'h0);
      check_head("one");
      wr(4'd0, 32'h1);
      check_status("one_after_pop");

      // Fill to DEPTH, then one more frame overflows
      do_reset();
      for (int c = 1; c <= 17; c++) drive(gen(16'(c)), 4);
      rd(4'd0, d);
      chk("full_status", d, 32'h0001_0610);
      check_status("full_model");
      for (int k = 0; k < 16; k++) begin
         check_head($sformatf("drain%0d", k));
         wr(4'd0, 32'h1);
      end
      check_status("drained");
      check_head("drained");
      wr(4'd0, 32'h2);
      rd(4'd0, d);
      chk("cleared_status", d, 32'h0000_0100);

      // Counter gap 1 -> 3
      do_reset();
      drive(gen(16'd1), 5);
      drive(gen(16'd3), 5);
      rd(4'd0, d);
      chk("gap_status", d, 32'h0000_0802);
      wr(4'd0, 32'h2);
      check_status("gap_cleared");
      for (int k = 0; k < 2; k++) begin
         check_head($sformatf("gap_head%0d", k));
         wr(4'd0, 32'h1);
      end

      // Pop coinciding with capture on a full FIFO
      do_reset();
      for (int c = 1; c <= 16; c++) drive(gen(16'(c)), 4);
      r = gen(16'd17);
      @(negedge clk);
      counter_in = r.t; freqs_in = r.f; amplitudes_in = r.a;
      @(negedge clk);
      @(negedge clk);
      chipselect = 1'b1; write = 1'b1; address = 4'd0; writedata = 32'h1;
      @(negedge clk);
      chipselect = 1'b0; write = 1'b0;
      void'(sb.pop_front());
      model_frame(r);
      repeat (3) @(negedge clk);
      rd(4'd0, d);
      chk("coinc_status", d, 32'h0000_0210);
      for (int k = 0; k < 16; k++) begin
         check_head($sformatf("coinc%0d", k));
         wr(4'd0, 32'h1);
      end
      check_status("coinc_drained");

      // Unstable counter, then settle at 9
      do_reset();
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         r = gen(16'((k % 2) ? 6 : 5));
         counter_in = r.t; freqs_in = r.f; amplitudes_in = r.a;
      end
      drive(gen(16'd9), 10);
      rd(4'd0, d);
      chk("toggle_status", d, 32'h0000_0801);
      check_head("toggle");
      wr(4'd0, 32'h1);
      check_status("toggle_popped");
      wr(4'd0, 32'h1);
      check_status("pop_empty");

      // Reset in the middle of a stream
      drive(gen(16'd10), 5);
      drive(gen(16'd11), 5);
      check_status("pre_reset");
      @(negedge clk);
      reset = 1'b1;
      sb.delete();
      ovf_m = 1'b0; gap_m = 1'b0; drop_m = 0; last_m = '0;
      #1 chk("midrst_readdata", readdata, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      model_frame(gen(16'd11));
      repeat (6) @(negedge clk);
      rd(4'd0, d);
      chk("post_reset_status", d, 32'h0000_0801);
      check_head("post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/peaks_reader.md
# peaks_reader

Consumer-side block for the peaks stage. It watches the peak-set outputs (`counter_in`, `freqs_in`, `amplitudes_in`) and captures each new frame into a DEPTH-entry frame FIFO. The HPS drains the FIFO over a 32-bit memory-mapped slave port. It sits between the peaks stage and the lightweight HPS bridge.

## Interface
Parameters:
- PEAKS, 6: peaks per frame; must match the peaks stage.
- FREQ_W, 8: frequency index width; at most 16.
- AMPL_W, 8: final signed amplitude width; at most 16.
- TIME_W, 16: frame counter width; at most 32.
- DEPTH, 16: FIFO depth in frames; power of 2, at least 2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- counter_in  in  TIME_W  frame counter from the peaks stage; increments once per new peak set
- freqs_in  in  PEAKS x FREQ_W  peak frequency indices
- amplitudes_in  in  PEAKS x AMPL_W (signed)  peak amplitudes
- chipselect  in  1  slave select
- read  in  1  read strobe; qualified by chipselect
- write  in  1  write strobe; qualified by chipselect
- address  in  4  register index
- writedata  in  32  write data
- readdata  out  32  registered read data

## Operation
- Input staging: all inputs are registered twice (s1, s2) on every clk. The inputs are driven from a different edge, so nothing is used unregistered.
- Capture condition: s1 equals s2 on all fields (stable) AND s2.counter is not equal to last_counter.
  - On capture, s2 is pushed to the FIFO and last_counter is set to s2.counter.
  - last_counter resets to 0, so the post-reset counter value 0 is never captured.
- Gap detection: on capture, if s2.counter is not equal to last_counter+1 (mod 2^TIME_W), set sticky GAP.
- Frame record: {counter, freq[0..PEAKS-1], ampl[0..PEAKS-1]}. The FIFO is register-based, with read and write pointers of log2(DEPTH)+1 bits.
- Full, push arrives, no pop: frame dropped, sticky OVF set, drop counter incremented (saturating at 255).
- Push and pop in the same cycle while full: the pop is applied first, then the push. Count is unchanged and no overflow.
- Push and pop in the same cycle while empty: the pop is ignored and the push is stored.
- Pop while empty: ignored, no error.
- Register map (readdata):
  - 0 STATUS: [7:0] frame count (0..DEPTH), [8] empty, [9] full, [10] OVF, [11] GAP, [23:16] drop counter.
  - 1 HEAD_TIME: head frame counter, zero-extended. Reads 0 when empty.
  - 2..2+PEAKS-1 HEAD_PEAK i:
    - [31:16] ampl[i], sign-extended.
    - [15:0] freq[i], zero-extended.
    - Reads 0 when empty.
  - Other addresses read 0.
- Writes:
  - Address 0, writedata[0]=1: pop the head frame.
  - Address 0, writedata[1]=1: clear OVF, GAP and the drop counter.
  - Both bits may be set in one write. Writes to other addresses are ignored.
- Reads have no side effects.

## Timing
- Reset values:
  - readdata = 0.
  - FIFO empty (count 0, empty=1).
  - OVF, GAP, drop counter = 0.
  - s1, s2, last_counter = 0.
- Capture latency: inputs that change before clk edge E and stay stable are pushed at edge E+2. STATUS count reflects the frame for reads issued from cycle E+3 on.
- Any input change within the capture window delays capture until two consecutive equal samples are seen.
- Read latency: 1 cycle.
  - readdata is registered at the edge where chipselect&read is sampled.
  - It is valid from that edge until the next read.
- Pop: takes effect at the write edge; a read issued on the next cycle sees the new head. The same rule applies to status clears.
- A frame of inputs must stay stable for at least 3 clk cycles to be captured. The peaks output rate satisfies this by a large margin.
- Reset asserted mid-operation: everything returns to reset values immediately, including FIFO contents. After deassertion, the current non-zero counter_in is captured once it is stable.

## Test plan
- Reset, then one frame: counter_in=1, freqs={3,40,70,110,160,230}, amplitudes={-5,12,7,100,-128,127}, held for 10 cycles.
  - STATUS count=1, empty=0.
  - HEAD_TIME=1.
  - HEAD_PEAK 0 = 0xFFFB0003.
  - HEAD_PEAK 4 = 0xFF8000A0.
- Counter held at 0 after reset for 50 cycles: STATUS=0x00000100 (empty), no capture.
- Push frames 1..16 (DEPTH=16), then frame 17:
  - count=16, full=1, OVF=1, drop=1.
  - Pop all 16: HEAD_TIME reads 1..16 in order, then empty=1.
- Counter jumps 1 -> 3: GAP=1 and both frames are stored. Writing 0x2 to address 0 clears GAP, OVF and drop.
- Full FIFO with a pop write coinciding with capture of a new frame: count stays 16, OVF=0, new frame is at the tail.
- Counter toggles every cycle for 20 cycles, then settles at 9: only frame 9 is captured (count=1). Pop on an empty FIFO leaves count=0. Reset mid-stream clears count to 0.
